// File: rtl/arbitrated_request_queue.sv
// Per-requestor request FIFOs whose non-empty mask drives a round-robin arbiter;
// the granted head entry is popped into a single registered valid/ready output slot.
module arbitrated_request_queue #(
    parameter int NUM_REQUESTORS = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQUESTORS-1:0]          in_valid,
    input  logic [NUM_REQUESTORS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_REQUESTORS-1:0]          in_ready,
    output logic [NUM_REQUESTORS-1:0]          arb_request,
    output logic                               arb_update_lru,
    input  logic [NUM_REQUESTORS-1:0]          arb_grant_oh,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [NUM_REQUESTORS-1:0]          out_source_oh,
    input  logic                               out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [NUM_REQUESTORS-1:0]            push_s;
    logic [NUM_REQUESTORS-1:0]            pop_s;
    logic [NUM_REQUESTORS*DATA_WIDTH-1:0] head_flat_s;
    logic [DATA_WIDTH-1:0]                head_sel_s;
    logic                                 load_en_s;
    logic                                 out_valid_r;
    logic [DATA_WIDTH-1:0]                out_data_r;
    logic [NUM_REQUESTORS-1:0]            out_source_oh_r;

    // A grant is only consumed when the output slot is free or draining this cycle.
    assign load_en_s      = (~out_valid_r | out_ready) & (|arb_grant_oh);
    assign pop_s          = arb_grant_oh & {NUM_REQUESTORS{load_en_s}};
    assign arb_update_lru = load_en_s;

    for (genvar g = 0; g < NUM_REQUESTORS; g++) begin : g_fifo
        logic [CW-1:0]         count_r;
        logic [PW-1:0]         wr_ptr_r;
        logic [PW-1:0]         rd_ptr_r;
        logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

        assign in_ready[g]    = (count_r != FULL_COUNT);
        assign arb_request[g] = (count_r != '0);
        assign push_s[g]      = in_valid[g] & in_ready[g];
        assign head_flat_s[g*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_ptr_r];

        // Pointer and occupancy bookkeeping for this source.
        always_ff @(posedge clk) begin
            if (!reset) begin
                count_r  <= '0;
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s[g]) begin
                    wr_ptr_r <= wr_ptr_r + PW'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s[g]) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                case ({push_s[g], pop_s[g]})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
            end
        end

        // Payload storage; slots are don't-care until written.
        always_ff @(posedge clk) begin
            if (push_s[g]) begin
                mem_r[wr_ptr_r] <= in_data[g*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Select the head entry of the granted source.
    always_comb begin
        head_sel_s = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            if (arb_grant_oh[i]) begin
                head_sel_s = head_sel_s | head_flat_s[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                head_sel_s = head_sel_s;
            end
        end
    end

    // Output slot: refill on load, otherwise empty on accept, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_r     <= 1'b0;
            out_data_r      <= '0;
            out_source_oh_r <= '0;
        end else if (load_en_s) begin
            out_valid_r     <= 1'b1;
            out_data_r      <= head_sel_s;
            out_source_oh_r <= arb_grant_oh;
        end else if (out_valid_r & out_ready) begin
            out_valid_r     <= 1'b0;
            out_data_r      <= out_data_r;
            out_source_oh_r <= out_source_oh_r;
        end else begin
            out_valid_r     <= out_valid_r;
            out_data_r      <= out_data_r;
            out_source_oh_r <= out_source_oh_r;
        end
    end

    assign out_valid     = out_valid_r;
    assign out_data      = out_data_r;
    assign out_source_oh = out_source_oh_r;

    arbitrated_request_queue_checker #(
        .NUM_REQUESTORS(NUM_REQUESTORS)
    ) u_checker (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .arb_request (arb_request),
        .arb_grant_oh(arb_grant_oh),
        .pop         (pop_s)
    );
endmodule

// Protocol checks on the arbiter handshake and the source push discipline.
module arbitrated_request_queue_checker #(
    parameter int NUM_REQUESTORS = 4
) (
    input logic                      clk,
    input logic                      reset,
    input logic [NUM_REQUESTORS-1:0] in_valid,
    input logic [NUM_REQUESTORS-1:0] in_ready,
    input logic [NUM_REQUESTORS-1:0] arb_request,
    input logic [NUM_REQUESTORS-1:0] arb_grant_oh,
    input logic [NUM_REQUESTORS-1:0] pop
);
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(arb_grant_oh));
    a_grant_requested: assert property (@(posedge clk) disable iff (!reset)
        (arb_grant_oh & ~arb_request) == '0);
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        (in_valid & ~in_ready) == '0);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
        (pop & ~arb_request) == '0);
endmodule

// File: tb/tb_arbitrated_request_queue.sv
// Self-checking bench: a round-robin arbiter model closes the grant loop and a
// scoreboard of expected (data, source) pairs is compared as outputs are accepted.
module tb_arbitrated_request_queue;
    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    arb_request;
    logic            arb_update_lru;
    logic [N-1:0]    arb_grant_oh;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    out_source_oh;
    logic            out_ready;

    logic [1:0]      rr_last;
    logic            grant_found;
    int              checks;
    int              errors;
    logic [DW-1:0]   exp_data_q[$];
    logic [N-1:0]    exp_src_q[$];

    arbitrated_request_queue #(
        .NUM_REQUESTORS(N),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .arb_request   (arb_request),
        .arb_update_lru(arb_update_lru),
        .arb_grant_oh  (arb_grant_oh),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_source_oh (out_source_oh),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin arbiter model: search starts just after the last consumed grant.
    always_comb begin
        arb_grant_oh = 4'b0000;
        grant_found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!grant_found && arb_request[(int'(rr_last) + k) % N]) begin
                arb_grant_oh[(int'(rr_last) + k) % N] = 1'b1;
                grant_found = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            rr_last <= 2'd3;
        end else if (arb_update_lru) begin
            for (int k = 0; k < N; k++) begin
                if (arb_grant_oh[k]) rr_last <= 2'(k);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 4'hF;
        in_data   = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
        out_ready = 1'b0;
        repeat (3) cyc();
        reset    = 1'b1;
        in_valid = 4'h0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (arb_request !== 4'h0) begin errors++; $display("FAIL reset_arb_request: got %b expected 0000", arb_request); end
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL reset_in_ready: got %b expected 1111", in_ready); end
        checks++; if (arb_update_lru !== 1'b0) begin errors++; $display("FAIL reset_update_lru: got %b expected 0", arb_update_lru); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_source_oh !== 4'h0) begin errors++; $display("FAIL reset_out_source: got %b expected 0000", out_source_oh); end
        out_ready = 1'b1;
        repeat (2) cyc();
        checks++; if (arb_request !== 4'h0) begin errors++; $display("FAIL reset_nothing_stored: arb_request %b expected 0000", arb_request); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_output: out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] ed;
        logic [N-1:0]  es;
        int            first_t;
        int            last_t;
        first_t   = -1;
        last_t    = -1;
        out_ready = 1'b1;
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < N; i++) begin
                in_data[i*DW +: DW] = 32'h0000_1000 + 32'(i * 16 + e);
                exp_data_q.push_back(32'h0000_1000 + 32'(i * 16 + e));
                exp_src_q.push_back(4'b0001 << i);
            end
            in_valid = 4'hF;
            cyc();
        end
        in_valid = 4'h0;
        for (int t = 0; t < 40; t++) begin
            if (exp_data_q.size() == 0) break;
            if (out_valid && out_ready) begin
                ed = exp_data_q.pop_front();
                es = exp_src_q.pop_front();
                checks++;
                if (out_data !== ed || out_source_oh !== es) begin
                    errors++;
                    $display("FAIL rr_output: got data %h src %b, expected data %h src %b", out_data, out_source_oh, ed, es);
                end
                if (first_t < 0) first_t = t;
                last_t = t;
            end
            cyc();
        end
        checks++; if (exp_data_q.size() != 0) begin errors++; $display("FAIL rr_timeout: %0d outputs outstanding, expected 0", exp_data_q.size()); end
        checks++; if (first_t != 0 || last_t != 7) begin errors++; $display("FAIL rr_back_to_back: outputs in cycles %0d..%0d, expected 0..7", first_t, last_t); end
        exp_data_q.delete();
        exp_src_q.delete();
    endtask

    task automatic test_single_source();
        logic [DW-1:0] ed;
        logic [N-1:0]  es;
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        in_data[2*DW +: DW] = 32'h0000_00A5;
        exp_data_q.push_back(32'h0000_00A5);
        exp_src_q.push_back(4'b0100);
        cyc();
        in_valid = 4'h0;
        checks++; if (arb_request !== 4'b0100) begin errors++; $display("FAIL single_request: got %b expected 0100", arb_request); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_not_yet: out_valid %b expected 0", out_valid); end
        checks++; if (arb_update_lru !== 1'b1) begin errors++; $display("FAIL single_update_lru: got %b expected 1", arb_update_lru); end
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        ed = exp_data_q.pop_front();
        es = exp_src_q.pop_front();
        checks++;
        if (out_data !== ed || out_source_oh !== es) begin
            errors++;
            $display("FAIL single_output: got data %h src %b, expected data %h src %b", out_data, out_source_oh, ed, es);
        end
        checks++; if (arb_request !== 4'h0) begin errors++; $display("FAIL single_fifo_empty: arb_request %b expected 0000", arb_request); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_accepted: out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ed;
        logic [N-1:0]  es;
        int            first_t;
        int            last_t;
        first_t   = -1;
        last_t    = -1;
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            in_valid = 4'b0010;
            in_data[DW +: DW] = 32'h0000_0011 + 32'(v);
            exp_data_q.push_back(32'h0000_0011 + 32'(v));
            exp_src_q.push_back(4'b0010);
            cyc();
        end
        in_valid = 4'h0;
        repeat (2) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin errors++; $display("FAIL bp_held: got valid %b data %h, expected valid 1 data 00000011", out_valid, out_data); end
            checks++; if (arb_update_lru !== 1'b0) begin errors++; $display("FAIL bp_update_lru: got %b expected 0", arb_update_lru); end
            checks++; if (arb_request !== 4'b0010) begin errors++; $display("FAIL bp_request: got %b expected 0010", arb_request); end
            cyc();
        end
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (exp_data_q.size() == 0) break;
            if (out_valid && out_ready) begin
                ed = exp_data_q.pop_front();
                es = exp_src_q.pop_front();
                checks++;
                if (out_data !== ed || out_source_oh !== es) begin
                    errors++;
                    $display("FAIL bp_output: got data %h src %b, expected data %h src %b", out_data, out_source_oh, ed, es);
                end
                if (first_t < 0) first_t = t;
                last_t = t;
            end
            cyc();
        end
        checks++; if (exp_data_q.size() != 0) begin errors++; $display("FAIL bp_timeout: %0d outputs outstanding, expected 0", exp_data_q.size()); end
        checks++; if (first_t != 0 || last_t != 2) begin errors++; $display("FAIL bp_back_to_back: outputs in cycles %0d..%0d, expected 0..2", first_t, last_t); end
        checks++; if (out_valid !== 1'b0 || arb_request !== 4'h0) begin errors++; $display("FAIL bp_drained: valid %b request %b, expected 0 and 0000", out_valid, arb_request); end
        exp_data_q.delete();
        exp_src_q.delete();
    endtask

    task automatic test_full_wrap();
        logic [DW-1:0] ed;
        logic [N-1:0]  es;
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL full_ready_before_%0d: got %b expected 1", v, in_ready[0]); end
            in_valid = 4'b0001;
            in_data[0 +: DW] = 32'(v);
            exp_data_q.push_back(32'(v));
            exp_src_q.push_back(4'b0001);
            cyc();
        end
        in_valid = 4'h0;
        // Entry 6 waits on in_ready, which must stay low while the slot is blocked.
        repeat (3) begin
            checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL full_not_ready: in_ready[0] %b expected 0", in_ready[0]); end
            checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL full_held: out_data %h expected 00000001", out_data); end
            cyc();
        end
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (exp_data_q.size() == 0) break;
            if (out_valid && out_ready) begin
                ed = exp_data_q.pop_front();
                es = exp_src_q.pop_front();
                checks++;
                if (out_data !== ed || out_source_oh !== es) begin
                    errors++;
                    $display("FAIL full_output: got data %h src %b, expected data %h src %b", out_data, out_source_oh, ed, es);
                end
            end
            cyc();
        end
        checks++; if (exp_data_q.size() != 0) begin errors++; $display("FAIL full_timeout: %0d outputs outstanding, expected 0", exp_data_q.size()); end
        checks++; if (in_ready[0] !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL full_drained: in_ready[0] %b valid %b, expected 1 and 0", in_ready[0], out_valid); end
        exp_data_q.delete();
        exp_src_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] ed;
        logic [N-1:0]  es;
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            in_valid = 4'b1100;
            in_data[2*DW +: DW] = 32'h0000_2000 + 32'(v);
            in_data[3*DW +: DW] = 32'h0000_3000 + 32'(v);
            cyc();
        end
        in_valid = 4'h0;
        checks++; if (out_valid !== 1'b1 || arb_request !== 4'b1100) begin errors++; $display("FAIL mid_prefill: valid %b request %b, expected 1 and 1100", out_valid, arb_request); end
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (arb_request !== 4'h0) begin errors++; $display("FAIL mid_arb_request: got %b expected 0000", arb_request); end
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL mid_in_ready: got %b expected 1111", in_ready); end
        for (int v = 0; v < 3; v++) begin
            in_valid = 4'b1000;
            in_data[3*DW +: DW] = 32'h0000_4000 + 32'(v);
            exp_data_q.push_back(32'h0000_4000 + 32'(v));
            exp_src_q.push_back(4'b1000);
            cyc();
        end
        in_valid  = 4'h0;
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (exp_data_q.size() == 0) break;
            if (out_valid && out_ready) begin
                ed = exp_data_q.pop_front();
                es = exp_src_q.pop_front();
                checks++;
                if (out_data !== ed || out_source_oh !== es) begin
                    errors++;
                    $display("FAIL mid_output: got data %h src %b, expected data %h src %b", out_data, out_source_oh, ed, es);
                end
            end
            cyc();
        end
        checks++; if (exp_data_q.size() != 0) begin errors++; $display("FAIL mid_timeout: %0d outputs outstanding, expected 0", exp_data_q.size()); end
        checks++; if (out_valid !== 1'b0 || arb_request !== 4'h0) begin errors++; $display("FAIL mid_drained: valid %b request %b, expected 0 and 0000", out_valid, arb_request); end
        exp_data_q.delete();
        exp_src_q.delete();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        in_valid  = 4'h0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single_source();
        test_backpressure();
        test_full_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
